// File: rtl/pcs_pkg.sv
// Shared PCS receive-side constants, lock FSM state type and header helper.
package pcs_pkg;

  localparam int unsigned HDR_W      = 2;
  localparam logic [1:0]  HDR_DATA   = 2'b01;
  localparam logic [1:0]  HDR_CTRL   = 2'b10;
  localparam int unsigned GB_SEQ_LEN = 33;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  // A sync header is legal only when its two bits differ.
  function automatic logic hdr_is_valid(input logic [HDR_W-1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Block-lock FSM: watches framed sync headers and requests bit slips until
// a run of LOCK_CNT legal headers is seen. Built only when
// RX_GEARBOX_BLOCK_LOCK_EN is defined.
`ifdef RX_GEARBOX_BLOCK_LOCK_EN
module rx_block_lock
  import pcs_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned INVLD_MAX = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [HDR_W-1:0] i_hdr,
  input  logic             i_hdr_valid,
  output logic             o_slip,
  output logic             o_block_lock
);

  localparam int unsigned CNT_W     = $clog2(LOCK_CNT + 1);
  localparam int unsigned WAIT_HDRS = 2;

  lock_state_t      state_q, state_d;
  logic [CNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0] invld_cnt_q, invld_cnt_d;
  logic [CNT_W-1:0] invld_next_c;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic             slip_d, lock_d;

  // State, counters and the registered slip/lock outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= UNLOCKED;
      hdr_cnt_q    <= '0;
      invld_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      invld_cnt_q  <= invld_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      o_slip       <= slip_d;
      o_block_lock <= lock_d;
    end
  end

  // Next-state: one decision per framed header; headers already in the
  // gearbox pipeline at slip time are skipped in SLIP_WAIT.
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    invld_cnt_d  = invld_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    slip_d       = 1'b0;
    lock_d       = o_block_lock;
    invld_next_c = invld_cnt_q + CNT_W'(!hdr_is_valid(i_hdr));
    if (i_hdr_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (hdr_is_valid(i_hdr)) begin
            if (hdr_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              lock_d      = 1'b1;
              hdr_cnt_d   = '0;
              invld_cnt_d = '0;
            end else begin
              hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d     = SLIP_WAIT;
            slip_d      = 1'b1;
            hdr_cnt_d   = '0;
            invld_cnt_d = '0;
            wait_cnt_d  = '0;
          end
        end
        SLIP_WAIT: begin
          if (wait_cnt_q == 2'(WAIT_HDRS - 1)) begin
            state_d    = UNLOCKED;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
        LOCKED: begin
          if (invld_next_c == CNT_W'(INVLD_MAX)) begin
            state_d     = SLIP_WAIT;
            lock_d      = 1'b0;
            slip_d      = 1'b1;
            hdr_cnt_d   = '0;
            invld_cnt_d = '0;
            wait_cnt_d  = '0;
          end else if (hdr_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
            hdr_cnt_d   = '0;
            invld_cnt_d = '0;
          end else begin
            hdr_cnt_d   = hdr_cnt_q + CNT_W'(1);
            invld_cnt_d = invld_next_c;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

endmodule
`endif

// File: rtl/rx_gearbox.sv
// 32b -> 66b receive gearbox: re-frames the SerDes bit stream into
// {sync header, payload lo} / {payload hi} words with single-bit slip.
// Optional block-lock FSM: define RX_GEARBOX_BLOCK_LOCK_EN.
module rx_gearbox
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned INVLD_MAX  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_slip,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [HDR_W-1:0]      o_hdr,
  output logic                  o_data_valid,
  output logic                  o_hdr_valid,
  output logic                  o_block_lock
);

  localparam int unsigned BUF_W    = 3 * DATA_WIDTH;
  localparam int unsigned FILL_W   = $clog2(BUF_W + 1);
  localparam int unsigned PEND_W   = 6;
  localparam int unsigned HDR_WORD = DATA_WIDTH + HDR_W;

  typedef enum logic {
    PH_HDR  = 1'b0,
    PH_DATA = 1'b1
  } phase_t;

  phase_t                phase_q, phase_d;
  logic [BUF_W-1:0]      sr_q, sr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [PEND_W-1:0]     pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [HDR_W-1:0]      hdr_d;
  logic                  dv_d, hv_d;
  logic                  slip_in_c;

`ifdef RX_GEARBOX_BLOCK_LOCK_EN
  logic fsm_slip;

  rx_block_lock #(
    .LOCK_CNT  (LOCK_CNT),
    .INVLD_MAX (INVLD_MAX)
  ) u_block_lock (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_hdr        (o_hdr),
    .i_hdr_valid  (o_hdr_valid),
    .o_slip       (fsm_slip),
    .o_block_lock (o_block_lock)
  );

  assign slip_in_c = i_slip | fsm_slip;
`else
  logic unused_lock_cfg;

  assign unused_lock_cfg = ^{32'(LOCK_CNT), 32'(INVLD_MAX)};
  assign o_block_lock    = 1'b0;
  assign slip_in_c       = i_slip;
`endif

  // Buffer, fill level, pending slips, phase and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      phase_q      <= PH_HDR;
      sr_q         <= '0;
      fill_q       <= '0;
      pend_q       <= '0;
      o_data       <= '0;
      o_hdr        <= '0;
      o_data_valid <= 1'b0;
      o_hdr_valid  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      pend_q       <= pend_d;
      o_data       <= data_d;
      o_hdr        <= hdr_d;
      o_data_valid <= dv_d;
      o_hdr_valid  <= hv_d;
    end
  end

  // Append new bits, drop one oldest bit if a slip is owed, then emit.
  // Bits above the fill level are kept zero so appending is a plain OR.
  always_comb begin
    phase_d = phase_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    pend_d  = pend_q;
    data_d  = o_data;
    hdr_d   = o_hdr;
    dv_d    = 1'b0;
    hv_d    = 1'b0;

    if (i_data_valid) begin
      sr_d   = sr_q | (BUF_W'(i_data) << fill_q);
      fill_d = fill_q + FILL_W'(DATA_WIDTH);
    end

    if (slip_in_c && (pend_q != '1)) begin
      pend_d = pend_q + PEND_W'(1);
    end
    if ((pend_d != '0) && (fill_d != '0)) begin
      sr_d   = sr_d >> 1;
      fill_d = fill_d - FILL_W'(1);
      pend_d = pend_d - PEND_W'(1);
    end

    if ((phase_q == PH_HDR) && (fill_d >= FILL_W'(HDR_WORD))) begin
      hdr_d   = sr_d[HDR_W-1:0];
      data_d  = sr_d[HDR_WORD-1:HDR_W];
      dv_d    = 1'b1;
      hv_d    = 1'b1;
      sr_d    = sr_d >> HDR_WORD;
      fill_d  = fill_d - FILL_W'(HDR_WORD);
      phase_d = PH_DATA;
    end else if ((phase_q == PH_DATA) && (fill_d >= FILL_W'(DATA_WIDTH))) begin
      data_d  = sr_d[DATA_WIDTH-1:0];
      dv_d    = 1'b1;
      sr_d    = sr_d >> DATA_WIDTH;
      fill_d  = fill_d - FILL_W'(DATA_WIDTH);
      phase_d = PH_HDR;
    end
  end

endmodule

// File: tb/tb_rx_gearbox.sv
// Self-checking bench for rx_gearbox: directed vector table, hand sequences
// and randomized traffic against a bit-queue reference model.
module tb_rx_gearbox;
  import pcs_pkg::*;

  localparam logic [31:0] P_LO = 32'h89AB_CDEF;
  localparam logic [31:0] P_HI = 32'h0123_4567;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_data_valid, i_slip;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic [1:0]  o_hdr;
  logic        o_data_valid, o_hdr_valid, o_block_lock;

  rx_gearbox #(.DATA_WIDTH(32), .LOCK_CNT(64), .INVLD_MAX(16)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_slip       (i_slip),
    .o_data       (o_data),
    .o_hdr        (o_hdr),
    .o_data_valid (o_data_valid),
    .o_hdr_valid  (o_hdr_valid),
    .o_block_lock (o_block_lock)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the receive buffer as a plain bit queue.
  bit          mq[$];
  int          m_pend;
  bit          m_in_data;
  logic [31:0] m_data;
  logic [1:0]  m_hdr;
  bit          m_dv, m_hv;
  bit          model_on = 1'b1;
  bit          const_chk = 1'b0;

  // Transmit-side stream: blocks serialised LSB first.
  bit txq[$];
  int gen_mode = 0;  // 0 fixed payload hdr 01, 1 random legal, 2 random hdr 11

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [31:0] data;
    logic        exp_dv;
    logic        exp_hv;
    logic [1:0]  exp_hdr;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_in_data = 0; m_data = '0; m_hdr = '0; m_dv = 0; m_hv = 0;
  endtask

  task automatic model_step(input logic [31:0] d, input bit v, input bit s);
    if (v) for (int i = 0; i < 32; i++) mq.push_back(d[i]);
    if (s) m_pend++;
    if (m_pend > 0 && mq.size() > 0) begin
      void'(mq.pop_front());
      m_pend--;
    end
    m_dv = 0; m_hv = 0;
    if (!m_in_data && mq.size() >= 34) begin
      for (int i = 0; i < 2; i++) m_hdr[i] = mq.pop_front();
      for (int i = 0; i < 32; i++) m_data[i] = mq.pop_front();
      m_dv = 1; m_hv = 1; m_in_data = 1;
    end else if (m_in_data && mq.size() >= 32) begin
      for (int i = 0; i < 32; i++) m_data[i] = mq.pop_front();
      m_dv = 1; m_in_data = 0;
    end
  endtask

  task automatic push_block();
    logic [63:0] pl;
    logic [1:0]  h;
    if (gen_mode == 0) begin
      pl = {P_HI, P_LO};
      h  = HDR_DATA;
    end else begin
      pl = {$urandom, $urandom};
      h  = (gen_mode == 2) ? 2'b11 : (($urandom_range(0, 1) == 0) ? HDR_DATA : HDR_CTRL);
    end
    for (int i = 0; i < 2; i++) txq.push_back(h[i]);
    for (int i = 0; i < 64; i++) txq.push_back(pl[i]);
  endtask

  task automatic push_junk(input int n);
    logic [31:0] j;
    j = $urandom;
    for (int i = 0; i < n; i++) txq.push_back(j[i]);
  endtask

  task automatic next_word(output logic [31:0] w);
    while (txq.size() < 32) push_block();
    for (int i = 0; i < 32; i++) w[i] = txq.pop_front();
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [31:0] d, input bit v, input bit s);
    i_data = d; i_data_valid = v; i_slip = s;
    @(posedge i_clk);
    if (!i_reset_n) model_reset();
    else model_step(d, v, s);
    #1;
    if (model_on) begin
      chk("dv", o_data_valid, m_dv);
      chk("hv", o_hdr_valid, m_hv);
      chk("data", o_data, m_data);
      chk("hdr", o_hdr, m_hdr);
`ifndef RX_GEARBOX_BLOCK_LOCK_EN
      chk("lock_tied0", o_block_lock, 0);
`endif
    end
    if (const_chk && o_data_valid) begin
      if (o_hdr_valid) begin
        chk("blk_hdr", o_hdr, HDR_DATA);
        chk("blk_lo", o_data, P_LO);
      end else begin
        chk("blk_hi", o_data, P_HI);
      end
    end
  endtask

  task automatic do_reset(input int n);
    const_chk = 0;
    i_reset_n = 1'b0;
    repeat (n) step($urandom, 1'b1, 1'b0);
    i_reset_n = 1'b1;
    txq.delete();
  endtask

  vec_t        vecs[12];
  logic [31:0] w;
  int          n_dv, n_hv, last_bub, consec, bad_seen;
  bit          got, saw_bad;

  initial begin
    i_reset_n = 1'b0; i_data = '0; i_data_valid = 1'b0; i_slip = 1'b0;

    // Directed vectors: reset with toggling data, then an aligned stream with stalls.
    gen_mode = 0;
    for (int r = 0; r < 3; r++)
      vecs[r] = '{1'b0, 1'b1, (r % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 0, 0, 2'b00, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0, 0, 0, 2'b00, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0, 1, 1, HDR_DATA, P_LO};
    vecs[5] = '{1'b1, 1'b1, 32'h0, 1, 0, HDR_DATA, P_HI};
    vecs[6] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 0, 0, HDR_DATA, P_HI};
    vecs[7] = '{1'b1, 1'b1, 32'h0, 1, 1, HDR_DATA, P_LO};
    vecs[8] = '{1'b1, 1'b1, 32'h0, 1, 0, HDR_DATA, P_HI};
    vecs[9] = '{1'b1, 1'b0, 32'h1234_5678, 0, 0, HDR_DATA, P_HI};
    vecs[10] = '{1'b1, 1'b1, 32'h0, 1, 1, HDR_DATA, P_LO};
    vecs[11] = '{1'b1, 1'b1, 32'h0, 1, 0, HDR_DATA, P_HI};
    for (int r = 3; r < 12; r++) if (vecs[r].v) next_word(vecs[r].data);

    for (int r = 0; r < 12; r++) begin
      i_reset_n = vecs[r].rst_n;
      step(vecs[r].data, vecs[r].v, 1'b0);
      chk($sformatf("vec%0d_dv", r), o_data_valid, vecs[r].exp_dv);
      chk($sformatf("vec%0d_hv", r), o_hdr_valid, vecs[r].exp_hv);
      chk($sformatf("vec%0d_hdr", r), o_hdr, vecs[r].exp_hdr);
      chk($sformatf("vec%0d_data", r), o_data, vecs[r].exp_data);
    end

    // 330 back-to-back words: 320 outputs, 160 headers, a bubble every 33.
    do_reset(2);
    gen_mode = 1;
    n_dv = 0; n_hv = 0; last_bub = -1;
    for (int c = 0; c < 330; c++) begin
      next_word(w);
      step(w, 1'b1, 1'b0);
      if (o_data_valid) n_dv++;
      if (o_hdr_valid) n_hv++;
      if (!o_data_valid) begin
        if (last_bub < 0) chk("first_bubble_idx", c, 0);
        else chk("bubble_gap", c - last_bub, GB_SEQ_LEN);
        last_bub = c;
      end
    end
    chk("seq_dv_count", n_dv, 320);
    chk("seq_hv_count", n_hv, 160);

`ifndef RX_GEARBOX_BLOCK_LOCK_EN
    // Stream offset by 5 bits; two slips issued while the buffer is empty.
    do_reset(2);
    gen_mode = 0;
    push_junk(5);
    step($urandom, 1'b0, 1'b1);
    step($urandom, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin next_word(w); step(w, 1'b1, 1'b1); end
    n_hv = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 5) const_chk = 1;
      if ($urandom_range(0, 3) == 0) step($urandom, 1'b0, 1'b0);
      else begin next_word(w); step(w, 1'b1, 1'b0); end
      if (const_chk && o_hdr_valid) n_hv++;
    end
    chk("slip_align_blocks_seen", n_hv >= 20, 1);
    const_chk = 0;

    // Random data, stalls, slips and occasional resets against the model.
    i_reset_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) i_reset_n = 1'b0;
      step($urandom, $urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0);
      i_reset_n = 1'b1;
    end
`endif

    // One-cycle reset mid-block, then cold-start alignment again.
    do_reset(2);
    gen_mode = 0;
    for (int c = 0; c < 7; c++) begin next_word(w); step(w, 1'b1, 1'b0); end
    i_reset_n = 1'b0;
    step($urandom, 1'b1, 1'b0);
    chk("midrst_dv", o_data_valid, 0);
    chk("midrst_hv", o_hdr_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_hdr", o_hdr, 0);
    i_reset_n = 1'b1;
    txq.delete();
    next_word(w); step(w, 1'b1, 1'b0);
    chk("rerun_w0_dv", o_data_valid, 0);
    next_word(w); step(w, 1'b1, 1'b0);
    chk("rerun_w1_hv", o_hdr_valid, 1);
    chk("rerun_w1_data", o_data, P_LO);
    const_chk = 1;
    for (int c = 0; c < 20; c++) begin next_word(w); step(w, 1'b1, 1'b0); end
    const_chk = 0;

`ifdef RX_GEARBOX_BLOCK_LOCK_EN
    // Auto-slip from a 7-bit offset, lock on 64 legal headers, lose lock on 11s.
    do_reset(2);
    model_on = 0;
    gen_mode = 1;
    push_junk(7);
    got = 0; consec = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      next_word(w); step(w, 1'b1, 1'b0);
      if (o_hdr_valid) consec = hdr_is_valid(o_hdr) ? consec + 1 : 0;
      if (o_block_lock) got = 1;
    end
    chk("lock_acquired", got, 1);
    chk("lock_after_64_valid", consec >= 64, 1);
    for (int c = 0; c < 20; c++) begin
      next_word(w); step(w, 1'b1, 1'b0);
      if (o_hdr_valid) chk("locked_hdr_legal", hdr_is_valid(o_hdr), 1);
      chk("lock_held", o_block_lock, 1);
    end
    gen_mode = 2;
    got = 0; bad_seen = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      next_word(w); step(w, 1'b1, 1'b0);
      if (!o_block_lock) got = 1;
      else if (o_hdr_valid && o_hdr == 2'b11) bad_seen++;
    end
    chk("lock_lost", got, 1);
    chk("lost_after_16_bad", bad_seen >= 16, 1);
    gen_mode = 1;
    got = 0; saw_bad = 0;
    for (int c = 0; c < 6000 && !got; c++) begin
      next_word(w); step(w, 1'b1, 1'b0);
      if (c > 8 && o_hdr_valid && !hdr_is_valid(o_hdr)) saw_bad = 1;
      if (o_block_lock) got = 1;
    end
    chk("slip_after_loss", saw_bad, 1);
    chk("relock", got, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
